// File: rtl/fofb_cc_crc_pkg.sv
// Shared CRC32 definitions for the GTX link framer, RX checker and bench model.
// 16-bit-per-step engine: MSB-first, poly 0x04C11DB7, init 0, no reflection, no final XOR.
package fofb_cc_crc_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC_HI  = 2'd2,
        ST_CRC_LO  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        logic        crc;
    } out_word_t;

    // Data bit 15 is shifted in first, so d[0] and crc[16] meet at next[0].
    function automatic logic [31:0] crc32_d16(input logic [31:0] crc, input logic [15:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC32_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/fofb_cc_out_reg.sv
// One-entry output register with valid/ready; 1-cycle latency from load to out_vld.
// Backpressure: in_rdy = !out_vld | out_rdy; contents hold while out_vld & !out_rdy.
module fofb_cc_out_reg
    import fofb_cc_crc_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_vld,
    input  out_word_t in_dat,
    output logic      in_rdy,
    output logic      out_vld,
    output out_word_t out_dat,
    input  logic      out_rdy
);

    logic      vld_q, vld_d;
    out_word_t dat_q, dat_d;

    assign in_rdy  = !vld_q | out_rdy;
    assign out_vld = vld_q;
    assign out_dat = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (in_vld && in_rdy) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/fofb_cc_crc_tx_framer.sv
// TX CRC framer: forwards sop/eop payload frames and appends CRC32 as two trailing words.
// Latency 1 cycle; input stalls while the CRC words are emitted or the output slot is full.
module fofb_cc_crc_tx_framer
    import fofb_cc_crc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      s_data,
    input  logic             s_valid,
    input  logic             s_sop,
    input  logic             s_eop,
    output logic             s_ready,
    output logic [15:0]      m_data,
    output logic             m_valid,
    output logic             m_sop,
    output logic             m_eop,
    output logic             m_crc,
    input  logic             m_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err_sop
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tx_state_e        state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             err_sop_q, err_sop_d;
    logic             run_q;
    logic             slot_free;
    logic             accept;
    logic             ld_vld;
    out_word_t        ld_dat;
    out_word_t        out_dat;

    // run_q keeps s_ready low while reset is asserted and for the first edge after release.
    assign s_ready = run_q & slot_free & ((state_q == ST_IDLE) | (state_q == ST_PAYLOAD));
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        drop_cnt_d  = drop_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_sop_d   = 1'b0;
        ld_vld      = 1'b0;
        ld_dat      = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (s_sop) begin
                        crc_d   = crc32_d16(CRC32_INIT, s_data);
                        ld_vld  = 1'b1;
                        ld_dat  = '{data: s_data, sop: 1'b1, eop: 1'b0, crc: 1'b0};
                        state_d = s_eop ? ST_CRC_HI : ST_PAYLOAD;
                    end else begin
                        drop_cnt_d = drop_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    crc_d     = crc32_d16(crc_q, s_data);
                    ld_vld    = 1'b1;
                    ld_dat    = '{data: s_data, sop: 1'b0, eop: 1'b0, crc: 1'b0};
                    err_sop_d = s_sop;
                    if (s_eop) begin
                        state_d = ST_CRC_HI;
                    end
                end
            end
            ST_CRC_HI: begin
                if (slot_free) begin
                    ld_vld  = 1'b1;
                    ld_dat  = '{data: crc_q[31:16], sop: 1'b0, eop: 1'b0, crc: 1'b1};
                    state_d = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                if (slot_free) begin
                    ld_vld  = 1'b1;
                    ld_dat  = '{data: crc_q[15:0], sop: 1'b0, eop: 1'b1, crc: 1'b1};
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (m_valid && m_ready && m_eop) begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            err_sop_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_sop_q   <= err_sop_d;
            run_q       <= 1'b1;
        end
    end

    fofb_cc_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (ld_vld),
        .in_dat  (ld_dat),
        .in_rdy  (slot_free),
        .out_vld (m_valid),
        .out_dat (out_dat),
        .out_rdy (m_ready)
    );

    assign m_data    = out_dat.data;
    assign m_sop     = out_dat.sop;
    assign m_eop     = out_dat.eop;
    assign m_crc     = out_dat.crc;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign err_sop   = err_sop_q;

endmodule
